// File: rtl/fir_mac_ctrl.sv
// fir_mac_ctrl: sequencer and multiply-accumulate stage for the 32-tap shift_R delay line
module fir_mac_ctrl #(
  parameter int TAPS   = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40,
  parameter int FRAC   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] probka_we,
  input  logic              clear,
  output logic [DATA_W-1:0] probka_in,
  output logic              nowa_shift,
  output logic              reset_shift,
  output logic [ADDR_W-1:0] adres,
  input  logic [DATA_W-1:0] dane_shift,
  input  logic [COEF_W-1:0] wsp,
  output logic [DATA_W-1:0] wynik,
  output logic              wynik_valid,
  output logic              busy,
  output logic              overrun
);
  localparam int PW = DATA_W + COEF_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MINV = -(ACC_W'(1) <<< (DATA_W - 1));

  typedef enum logic [2:0] {IDLE, SHIFT, ADDR, DRAIN1, DRAIN2, OUT} state_t;

  state_t state, state_nxt;
  logic signed [PW-1:0] mul, prod;
  logic signed [ACC_W-1:0] acc, acc_sum, rnd;
  logic [DATA_W-1:0] sat;
  logic dv, pv, accept;

  assign accept      = start && state == IDLE && !clear;
  assign nowa_shift  = state == SHIFT;
  assign wynik_valid = state == OUT;
  assign busy        = state != IDLE;
  assign mul         = PW'($signed(dane_shift)) * PW'($signed(wsp));
  assign acc_sum     = acc + ACC_W'(prod);
  assign rnd         = (acc_sum + HALF) >>> FRAC;
  assign sat         = rnd > MAXV ? DATA_W'(MAXV) : rnd < MINV ? DATA_W'(MINV) : DATA_W'(rnd);

  // State register; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end

  // Next-state sequencing; clear aborts from any state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = start ? SHIFT : IDLE;
      SHIFT:   state_nxt = ADDR;
      ADDR:    state_nxt = adres == LAST ? DRAIN1 : ADDR;
      DRAIN1:  state_nxt = DRAIN2;
      DRAIN2:  state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Address walk, product/accumulate pipeline, output rounding and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      probka_in   <= '0;
      adres       <= '0;
      wynik       <= '0;
      reset_shift <= 1'b0;
      overrun     <= 1'b0;
      prod        <= '0;
      acc         <= '0;
      dv          <= 1'b0;
      pv          <= 1'b0;
    end else begin
      reset_shift <= clear;
      dv          <= state == ADDR && !clear;
      pv          <= dv && !clear;
      if (accept) probka_in <= probka_we;
      adres   <= clear ? '0 : state == ADDR ? (adres == LAST ? adres : adres + ADDR_W'(1)) : state == DRAIN2 ? '0 : adres;
      overrun <= clear ? 1'b0 : overrun | (start && state != IDLE);
      prod    <= clear ? '0 : dv ? mul : prod;
      acc     <= (clear || accept) ? '0 : pv ? acc_sum : acc;
      if (state == DRAIN2 && !clear) wynik <= sat;
    end
  end
endmodule

// File: tb/tb_fir_mac_ctrl.sv
// tb_fir_mac_ctrl: directed and randomized checks of fir_mac_ctrl against a convolution model
module tb_fir_mac_ctrl;
  logic clk = 0, rst = 1, start = 0, clear = 0;
  logic [15:0] probka_we = '0, probka_in, dane_shift = '0, wsp = '0, wynik;
  logic nowa_shift, reset_shift, wynik_valid, busy, overrun;
  logic [4:0] adres;
  logic [15:0] line [32];
  int coef [32];
  int hist [$];
  int checks = 0, failures = 0;
  int nn, vn, vc, rn;
  logic signed [15:0] r;

  fir_mac_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .probka_we(probka_we), .clear(clear),
    .probka_in(probka_in), .nowa_shift(nowa_shift), .reset_shift(reset_shift),
    .adres(adres), .dane_shift(dane_shift), .wsp(wsp), .wynik(wynik),
    .wynik_valid(wynik_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Environment: shift_R delay line (newest at address 0) and coefficient ROM, both registered-read.
  always @(posedge clk) begin
    dane_shift <= line[adres];
    wsp <= 16'(coef[adres]);
    for (int i = 0; i < 32; i++)
      line[i] <= reset_shift ? 16'h0 : nowa_shift ? (i == 0 ? probka_in : line[i-1]) : line[i];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_y();
    longint a = 0, y;
    for (int k = 0; k < 32 && k < hist.size(); k++) a += longint'(coef[k]) * longint'(hist[k]);
    y = (a + 16384) >>> 15;
    return y > 32767 ? 32767 : y < -32768 ? -32768 : y;
  endfunction

  task automatic clr();
    clear = 1;
    tick();
    clear = 0;
    hist.delete();
    chk("clear_pulse", reset_shift, 1);
  endtask

  task automatic run_sample(input int s);
    probka_we = 16'(s);
    start = 1;
    tick();
    start = 0;
    hist.push_front(s);
    if (hist.size() > 32) void'(hist.pop_back());
    chk("probka_in", $signed(probka_in), s);
    nn = 0; vn = 0; vc = 0;
    for (int c = 1; c <= 36; c++) begin
      if (nowa_shift) nn++;
      if (c == 1) chk("nowa_c1", nowa_shift, 1);
      if (c == 1 || c == 36) chk("busy_run", busy, 1);
      if (c >= 2 && c <= 33) chk("adres", adres, c - 2);
      if (wynik_valid) begin
        vn++; vc = c;
        chk("wynik", $signed(wynik), model_y());
      end
      tick();
    end
    chk("valid_cycle", vc, 36);
    chk("valid_count", vn, 1);
    chk("nowa_count", nn, 1);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin coef[k] = 0; line[k] = '0; end
    tick(); tick();
    chk("rst_probka_in", probka_in, 0);
    chk("rst_nowa", nowa_shift, 0);
    chk("rst_reset_shift", reset_shift, 0);
    chk("rst_adres", adres, 0);
    chk("rst_wynik", wynik, 0);
    chk("rst_valid", wynik_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst = 0;
    run_sample(5);
    chk("zero_coef_out", $signed(wynik), 0);

    coef[0] = 16384;
    clr();
    run_sample(16384);
    chk("impulse", $signed(wynik), 8192);

    for (int k = 0; k < 32; k++) coef[k] = 1024;
    clr();
    for (int n = 0; n < 32; n++) begin
      run_sample(1000);
      tick(); tick(); tick();
    end
    chk("step32", $signed(wynik), 1000);

    for (int k = 0; k < 32; k++) coef[k] = 32767;
    for (int n = 0; n < 32; n++) run_sample(32767);
    chk("sat_pos", $signed(wynik), 32767);
    for (int n = 0; n < 32; n++) run_sample(-32768);
    chk("sat_neg", $signed(wynik), -32768);

    clr();
    probka_we = 16'd111;
    start = 1;
    tick();
    start = 0;
    hist.push_front(111);
    nn = 0;
    for (int c = 1; c <= 19; c++) begin
      if (nowa_shift) nn++;
      start = (c == 10);
      probka_we = 16'd222;
      tick();
    end
    start = 0;
    chk("overrun_set", overrun, 1);
    chk("overrun_no_latch", probka_in, 111);
    chk("overrun_one_shift", nn, 1);
    clear = 1;
    tick();
    clear = 0;
    hist.delete();
    chk("abort_reset_shift", reset_shift, 1);
    chk("abort_overrun", overrun, 0);
    chk("abort_busy", busy, 0);
    chk("abort_nowa", nowa_shift, 0);
    vn = 0; rn = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (wynik_valid) vn++;
      if (reset_shift) rn++;
    end
    chk("abort_no_valid", vn, 0);
    chk("abort_single_rs", rn, 0);

    clear = 1; start = 1; probka_we = 16'd333;
    tick();
    clear = 0; start = 0;
    chk("cs_busy", busy, 0);
    chk("cs_overrun", overrun, 0);
    chk("cs_reset_shift", reset_shift, 1);
    chk("cs_probka_in", probka_in, 111);
    tick();
    chk("cs_no_shift", nowa_shift, 0);

    probka_we = 16'd444;
    start = 1;
    tick();
    start = 0;
    hist.push_front(444);
    for (int c = 1; c < 12; c++) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_adres", adres, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wynik", wynik, 0);
    vn = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (wynik_valid) vn++;
    end
    chk("mid_rst_no_valid", vn, 0);

    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 32; k++) begin
        r = 16'($urandom);
        coef[k] = r;
      end
      clr();
      for (int n = 0; n < 40; n++) begin
        r = 16'($urandom);
        run_sample(r);
        for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
